mips_muldiv: RTL and testbench

- Iterative multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sits beside the single-cycle ALU in the MIPS core and executes MULT, MULTU, DIV and DIVU, one result bit per cycle.
- Also services MTHI/MTLO writes; HI/LO are always readable for MFHI/MFLO.
- The core stalls its PC update while busy=1.

---
 rtl/mips_muldiv_if.sv | 29 ++
 rtl/mips_muldiv.sv | 133 +++++++++++++
 tb/tb_mips_muldiv.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_if.sv
// Core-side bus of the multiply/divide unit: operation request, MTHI/MTLO writes, HI/LO readback.
interface mips_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline/core side
  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  // Multiply/divide unit side
  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one result bit per cycle.
module mips_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          rst_b,
  mips_muldiv_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned DW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;      // raw dividend, kept for the divide-by-zero result
  logic [WIDTH-1:0] b_q;      // raw operand, replaced by its magnitude in PREP
  logic [DW-1:0]    acc;      // {upper, lower}: product or {remainder, quotient}
  logic [CNT_W-1:0] cnt;
  logic             q_neg;    // product / quotient sign
  logic             r_neg;    // remainder sign
  logic             dbz_q;

  logic             is_div, is_signed, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh, div_diff;
  logic             div_ge;
  logic [DW-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign b_zero    = (b_q == '0);

  // Operand magnitudes, one shift-add step, one restoring-divide step, and sign fix-up
  always_comb begin
    a_mag    = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag    = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    rem_sh   = acc[DW-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, b_q};
    div_ge   = ~div_diff[WIDTH];
    prod_fix = q_neg ? -acc : acc;
    quot_fix = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = r_neg ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];
  end

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = PREP;
      PREP:    state_nxt = (is_div && b_zero) ? FIX : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      op_q            <= '0;
      a_q             <= '0;
      b_q             <= '0;
      acc             <= '0;
      cnt             <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      dbz_q           <= 1'b0;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy        <= (state_nxt != IDLE);
      bus.done        <= (state == FIX);
      bus.div_by_zero <= dbz_q;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            dbz_q <= 1'b0;
            bus.div_by_zero <= 1'b0;
          end else begin
            if (bus.hi_we) bus.hi <= bus.wdata;
            if (bus.lo_we) bus.lo <= bus.wdata;
          end
        end
        PREP: begin
          acc   <= {{WIDTH{1'b0}}, a_mag};
          b_q   <= b_mag;
          cnt   <= CNT_W'(WIDTH);
          q_neg <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          r_neg <= is_signed & a_q[WIDTH-1];
          if (is_div && b_zero) begin
            dbz_q           <= 1'b1;
            bus.div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div)
            acc <= {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
          else
            acc <= {mul_sum, acc[WIDTH-1:1]};
        end
        FIX: begin
          if (!is_div) begin
            bus.hi <= prod_fix[DW-1:WIDTH];
            bus.lo <= prod_fix[WIDTH-1:0];
          end else if (dbz_q) begin
            bus.hi <= a_q;
            bus.lo <= '1;
          end else begin
            bus.hi <= rem_fix;
            bus.lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv at WIDTH=32.
module tb_mips_muldiv;
  logic clk;
  logic rst_b;
  int   checks;
  int   errors;
  int   lat;

  mips_muldiv_if #(.WIDTH(32)) bus ();

  mips_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Directed sequence
  initial begin
    checks = 0; errors = 0;
    rst_b = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi",   64'(bus.hi),   64'd0);
    check("rst_lo",   64'(bus.lo),   64'd0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    @(negedge clk); rst_b = 1'b1;

    // MULTU max*max
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("multu_lat",  64'(lat), 64'd34);
    check("multu_hi",   64'(bus.hi), 64'h0000_0000_FFFF_FFFE);
    check("multu_lo",   64'(bus.lo), 64'h0000_0000_0000_0001);
    check("multu_idle", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("done_pulse", 64'(bus.done), 64'd0);

    // MULT -3 * 7
    start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(lat);
    check("mult_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFEB);

    // DIV -7 / 2
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
    check("div_lo", 64'(bus.lo), 64'h0000_0000_FFFF_FFFD);
    check("div_hi", 64'(bus.hi), 64'h0000_0000_FFFF_FFFF);

    // DIVU 7 / 2
    start_op(2'b11, 32'd7, 32'd2);
    wait_done(lat);
    check("divu_lo", 64'(bus.lo), 64'd3);
    check("divu_hi", 64'(bus.hi), 64'd1);

    // Start accepted in the done cycle: DIV most-negative / -1
    bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'h8000_0000; bus.b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_done", 64'(bus.done), 64'd0);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(lat);
    check("ovf_lat", 64'(lat), 64'd34);
    check("ovf_lo",  64'(bus.lo), 64'h0000_0000_8000_0000);
    check("ovf_hi",  64'(bus.hi), 64'd0);
    check("ovf_dbz", 64'(bus.div_by_zero), 64'd0);

    // DIVU 5 / 0
    start_op(2'b11, 32'd5, 32'd0);
    wait_done(lat);
    check("dbz_lat",  64'(lat), 64'd2);
    check("dbz_flag", 64'(bus.div_by_zero), 64'd1);
    check("dbz_hi",   64'(bus.hi), 64'd5);
    check("dbz_lo",   64'(bus.lo), 64'h0000_0000_FFFF_FFFF);
    @(posedge clk); #1;
    check("dbz_hold", 64'(bus.div_by_zero), 64'd1);

    // MULTU 6*7 with start and MTHI attempted while busy
    start_op(2'b01, 32'd6, 32'd7);
    check("dbz_clear", 64'(bus.div_by_zero), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd1; bus.b = 32'd1;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    check("busy_hi_hold", 64'(bus.hi), 64'd5);
    wait_done(lat);
    check("ign_hi", 64'(bus.hi), 64'd0);
    check("ign_lo", 64'(bus.lo), 64'd42);

    // MTHI + MTLO together
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hABCD;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mt_hi", 64'(bus.hi), 64'hABCD);
    check("mt_lo", 64'(bus.lo), 64'hABCD);

    // start and MTLO in the same idle cycle: write dropped
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd2; bus.b = 32'd3;
    bus.lo_we = 1'b1; bus.wdata = 32'h5555;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.lo_we = 1'b0;
    check("drop_lo", 64'(bus.lo), 64'hABCD);
    wait_done(lat);
    check("drop_res_lo", 64'(bus.lo), 64'd6);
    check("drop_res_hi", 64'(bus.hi), 64'd0);

    // Asynchronous reset in CALC
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    start_op(2'b01, 32'd100, 32'd100);
    repeat (10) @(posedge clk);
    #2;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    check("pre_rst_hi",   64'(bus.hi), 64'hDEAD);
    rst_b = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_hi",   64'(bus.hi), 64'd0);
    check("arst_lo",   64'(bus.lo), 64'd0);
    @(negedge clk); rst_b = 1'b1;

    // MULTU 3*4 after reset
    start_op(2'b01, 32'd3, 32'd4);
    wait_done(lat);
    check("post_lat", 64'(lat), 64'd34);
    check("post_lo",  64'(bus.lo), 64'd12);
    check("post_hi",  64'(bus.hi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
